// File: rtl/simple_pkg.sv
// rtl/simple_pkg.sv - shared types and constants for the SIMPLE core pipeline
package simple_pkg;

  localparam int REG_ADDR_W = 3;
  localparam int DATA_W     = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_WR_WAIT = 2'd2
  } state_e;

  // memWrite encoding used by the execute stage
  typedef enum logic [1:0] {
    MEMW_NONE  = 2'd0,
    MEMW_READ  = 2'd1,
    MEMW_WRITE = 2'd2
  } mem_write_e;

  // Stores win over loads when the execute stage raises both enables
  function automatic mem_write_e mem_op(input logic read_en, input logic write_en);
    if (write_en)     return MEMW_WRITE;
    else if (read_en) return MEMW_READ;
    else              return MEMW_NONE;
  endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// rtl/mem_timeout_ctr.sv - wait-state counter that flags an overdue memory transaction
module mem_timeout_ctr #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [7:0] count_q;
  logic [7:0] count_d;

  // Clear on entry to a wait state, count every wait cycle without ack
  always_comb begin
    count_d = count_q;
    if (clr)     count_d = 8'd0;
    else if (en) count_d = count_q + 8'd1;
  end

  // Counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= 8'd0;
    else     count_q <= count_d;
  end

  // This un-acked wait cycle is the TIMEOUT-th one
  assign expired = en && (count_q == 8'(TIMEOUT - 1));

endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - memory/writeback stage: data-memory handshake, register writeback, retire count
module mem_wb_stage
  import simple_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     alu_result,
  input  logic                  write_reg,
  input  logic [REG_ADDR_W-1:0] reg_addr,
  input  logic [15:0]           mem_addr_in,
  input  logic [DATA_W-1:0]     store_data,
  input  logic                  read_en,
  input  logic                  write_en,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  stall,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]     rf_wdata,
  output logic                  mem_err,
  output logic [15:0]           retired
);

  state_e                state_q, state_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
  logic                  rf_we_q, rf_we_d;
  logic [REG_ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0]     rf_wdata_q, rf_wdata_d;
  logic                  mem_err_q, mem_err_d;
  logic [15:0]           retired_q, retired_d;
  logic                  lat_write_reg_q, lat_write_reg_d;
  logic [REG_ADDR_W-1:0] lat_reg_addr_q, lat_reg_addr_d;

  logic       ctr_clr;
  logic       ctr_en;
  logic       ctr_expired;
  mem_write_e op;

  // Only the low ADDR_W address bits reach data memory
  logic unused_addr_bits;
  assign unused_addr_bits = ^mem_addr_in;

  assign op     = mem_op(read_en, write_en);
  assign ctr_en = (state_q != ST_IDLE) && !mem_ack;

  mem_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (ctr_clr),
    .en      (ctr_en),
    .expired (ctr_expired)
  );

  // Next-state and output logic; rf_we defaults low so it is a one-cycle pulse
  always_comb begin
    state_d         = state_q;
    mem_req_d       = mem_req_q;
    mem_we_d        = mem_we_q;
    mem_addr_d      = mem_addr_q;
    mem_wdata_d     = mem_wdata_q;
    rf_we_d         = 1'b0;
    rf_waddr_d      = rf_waddr_q;
    rf_wdata_d      = rf_wdata_q;
    mem_err_d       = mem_err_q;
    retired_d       = retired_q;
    lat_write_reg_d = lat_write_reg_q;
    lat_reg_addr_d  = lat_reg_addr_q;
    ctr_clr         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (op == MEMW_WRITE) begin
          state_d     = ST_WR_WAIT;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = mem_addr_in[ADDR_W-1:0];
          mem_wdata_d = store_data;
          ctr_clr     = 1'b1;
        end else if (op == MEMW_READ) begin
          state_d         = ST_RD_WAIT;
          mem_req_d       = 1'b1;
          mem_we_d        = 1'b0;
          mem_addr_d      = mem_addr_in[ADDR_W-1:0];
          lat_write_reg_d = write_reg;
          lat_reg_addr_d  = reg_addr;
          ctr_clr         = 1'b1;
        end else begin
          rf_we_d    = write_reg;
          rf_waddr_d = reg_addr;
          rf_wdata_d = alu_result;
          if (write_reg) retired_d = retired_q + 16'd1;
        end
      end
      ST_RD_WAIT: begin
        if (mem_ack) begin
          rf_we_d    = lat_write_reg_q;
          rf_waddr_d = lat_reg_addr_q;
          rf_wdata_d = mem_rdata;
          mem_req_d  = 1'b0;
          state_d    = ST_IDLE;
          retired_d  = retired_q + 16'd1;
        end else if (ctr_expired) begin
          mem_req_d = 1'b0;
          state_d   = ST_IDLE;
          mem_err_d = 1'b1;
        end
      end
      ST_WR_WAIT: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = ST_IDLE;
          retired_d = retired_q + 16'd1;
        end else if (ctr_expired) begin
          mem_req_d = 1'b0;
          state_d   = ST_IDLE;
          mem_err_d = 1'b1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      mem_req_q       <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      rf_we_q         <= 1'b0;
      rf_waddr_q      <= '0;
      rf_wdata_q      <= '0;
      mem_err_q       <= 1'b0;
      retired_q       <= 16'd0;
      lat_write_reg_q <= 1'b0;
      lat_reg_addr_q  <= '0;
    end else begin
      state_q         <= state_d;
      mem_req_q       <= mem_req_d;
      mem_we_q        <= mem_we_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
      rf_we_q         <= rf_we_d;
      rf_waddr_q      <= rf_waddr_d;
      rf_wdata_q      <= rf_wdata_d;
      mem_err_q       <= mem_err_d;
      retired_q       <= retired_d;
      lat_write_reg_q <= lat_write_reg_d;
      lat_reg_addr_q  <= lat_reg_addr_d;
    end
  end

  assign stall     = (state_q != ST_IDLE);
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign mem_err   = mem_err_q;
  assign retired   = retired_q;

endmodule
